// File: rtl/rvfi_bus_harness.sv
// Bus harness: core reset sequencer, saturating cycle counter with one-shot checker
// enable, and per-channel valid/ready monitors. Optional trap gating: RVFI_BUS_HARNESS_TRAP_EN.
module rvfi_bus_harness #(
    parameter int unsigned NCH          = 1,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned CHECK_DEPTH  = 20,
    parameter int unsigned MAX_WAIT     = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        mem_valid,
    input  logic [NCH-1:0]        mem_ready,
    input  logic [NCH*XLEN-1:0]   mem_addr,
    input  logic [NCH*XLEN-1:0]   mem_wdata,
    input  logic [NCH*XLEN/8-1:0] mem_wstrb,
`ifdef RVFI_BUS_HARNESS_TRAP_EN
    input  logic                  trap,
    output logic                  env_ok,
`endif
    output logic                  core_resetn,
    output logic                  check_enable,
    output logic [CNT_W-1:0]      cycle,
    output logic [NCH-1:0]        stall_ok,
    output logic [NCH-1:0]        wait_viol,
    output logic [NCH-1:0]        stable_viol
);
    localparam int unsigned SW = XLEN / 8;
    localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_WAIT = 1'b1
    } ch_state_e;

    logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
    logic             core_resetn_q, core_resetn_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic             check_enable_q, check_enable_d;
    logic             ce_fired_q, ce_fired_d;
    logic             ce_block_s;

`ifdef RVFI_BUS_HARNESS_TRAP_EN
    logic trap_seen_q, trap_seen_d;

    // A trap only counts once the core is out of reset.
    always_comb begin
        trap_seen_d = trap_seen_q | (trap & core_resetn_q);
    end

    // Sticky trap flag register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            trap_seen_q <= 1'b0;
        end else begin
            trap_seen_q <= trap_seen_d;
        end
    end

    // Blocking on the next-state value suppresses an enable due on the trap edge itself.
    assign ce_block_s = trap_seen_d;
    assign env_ok     = (&stall_ok) & ~trap_seen_q;
`else
    assign ce_block_s = 1'b0;
`endif

    // Reset sequencer next state: count edges since release until the core reset lifts.
    always_comb begin
        rst_cnt_d     = rst_cnt_q;
        core_resetn_d = core_resetn_q;
        if (!core_resetn_q) begin
            rst_cnt_d = rst_cnt_q + RW'(1);
            if ((32'(rst_cnt_q) + 32'd1) >= RESET_CYCLES) begin
                core_resetn_d = 1'b1;
            end else begin
                core_resetn_d = 1'b0;
            end
        end else begin
            rst_cnt_d     = rst_cnt_q;
            core_resetn_d = 1'b1;
        end
    end

    // Saturating cycle counter next state.
    always_comb begin
        if (cycle_q == {CNT_W{1'b1}}) begin
            cycle_d = cycle_q;
        end else begin
            cycle_d = cycle_q + CNT_W'(1);
        end
    end

    // One-shot enable: the fired flag keeps a saturated count equal to CHECK_DEPTH from re-firing.
    always_comb begin
        check_enable_d = 1'b0;
        ce_fired_d     = ce_fired_q;
        if ((32'(cycle_q) == CHECK_DEPTH) && !ce_fired_q && !ce_block_s) begin
            check_enable_d = 1'b1;
            ce_fired_d     = 1'b1;
        end else begin
            check_enable_d = 1'b0;
        end
    end

    // Global sequencing/counter state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_cnt_q      <= {RW{1'b0}};
            core_resetn_q  <= 1'b0;
            cycle_q        <= {CNT_W{1'b0}};
            check_enable_q <= 1'b0;
            ce_fired_q     <= 1'b0;
        end else begin
            rst_cnt_q      <= rst_cnt_d;
            core_resetn_q  <= core_resetn_d;
            cycle_q        <= cycle_d;
            check_enable_q <= check_enable_d;
            ce_fired_q     <= ce_fired_d;
        end
    end

    assign core_resetn  = core_resetn_q;
    assign check_enable = check_enable_q;
    assign cycle        = cycle_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
        logic [XLEN-1:0]  cap_addr_q, cap_addr_d;
        logic [XLEN-1:0]  cap_wdata_q, cap_wdata_d;
        logic [SW-1:0]    cap_wstrb_q, cap_wstrb_d;
        logic             wait_viol_q, wait_viol_d;
        logic             stable_viol_q, stable_viol_d;
        logic [XLEN-1:0]  addr_s, wdata_s;
        logic [SW-1:0]    wstrb_s;
        logic             changed_s;

        assign addr_s    = mem_addr[i*XLEN +: XLEN];
        assign wdata_s   = mem_wdata[i*XLEN +: XLEN];
        assign wstrb_s   = mem_wstrb[i*SW +: SW];
        // Live payload against the value captured when the request first stalled.
        assign changed_s = (addr_s != cap_addr_q) || (wdata_s != cap_wdata_q) ||
                           (wstrb_s != cap_wstrb_q);

        // Channel FSM next state, wait counting and violation detection.
        always_comb begin
            state_d       = state_q;
            wait_cnt_d    = wait_cnt_q;
            cap_addr_d    = cap_addr_q;
            cap_wdata_d   = cap_wdata_q;
            cap_wstrb_d   = cap_wstrb_q;
            wait_viol_d   = wait_viol_q;
            stable_viol_d = stable_viol_q;
            case (state_q)
                CH_IDLE: begin
                    if (mem_valid[i] && !mem_ready[i]) begin
                        state_d     = CH_WAIT;
                        wait_cnt_d  = CNT_W'(1);
                        cap_addr_d  = addr_s;
                        cap_wdata_d = wdata_s;
                        cap_wstrb_d = wstrb_s;
                    end else begin
                        state_d    = CH_IDLE;
                        wait_cnt_d = {CNT_W{1'b0}};
                    end
                end
                CH_WAIT: begin
                    if (!mem_valid[i]) begin
                        state_d       = CH_IDLE;
                        wait_cnt_d    = {CNT_W{1'b0}};
                        stable_viol_d = 1'b1;
                    end else if (mem_ready[i]) begin
                        state_d       = CH_IDLE;
                        wait_cnt_d    = {CNT_W{1'b0}};
                        stable_viol_d = stable_viol_q | changed_s;
                    end else begin
                        state_d       = CH_WAIT;
                        stable_viol_d = stable_viol_q | changed_s;
                        if (wait_cnt_q == {CNT_W{1'b1}}) begin
                            wait_cnt_d = wait_cnt_q;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                        end
                        if (32'(wait_cnt_q) >= MAX_WAIT) begin
                            wait_viol_d = 1'b1;
                        end else begin
                            wait_viol_d = wait_viol_q;
                        end
                    end
                end
                default: begin
                    state_d    = CH_IDLE;
                    wait_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end

        // Channel state registers; reset drops any in-flight request without a violation.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q       <= CH_IDLE;
                wait_cnt_q    <= {CNT_W{1'b0}};
                cap_addr_q    <= {XLEN{1'b0}};
                cap_wdata_q   <= {XLEN{1'b0}};
                cap_wstrb_q   <= {SW{1'b0}};
                wait_viol_q   <= 1'b0;
                stable_viol_q <= 1'b0;
            end else begin
                state_q       <= state_d;
                wait_cnt_q    <= wait_cnt_d;
                cap_addr_q    <= cap_addr_d;
                cap_wdata_q   <= cap_wdata_d;
                cap_wstrb_q   <= cap_wstrb_d;
                wait_viol_q   <= wait_viol_d;
                stable_viol_q <= stable_viol_d;
            end
        end

        assign stall_ok[i]    = (32'(wait_cnt_q) < MAX_WAIT);
        assign wait_viol[i]   = wait_viol_q;
        assign stable_viol[i] = stable_viol_q;
    end

endmodule
